// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 key-schedule engine.
`timescale 1ns/1ps
package rc4_pkg;

    // Sequencer states. The shuffle walks RD_I -> RD_J -> WR_I -> WR_J once per i.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_RD_I   = 3'd2,
        ST_RD_J   = 3'd3,
        ST_WR_I   = 3'd4,
        ST_WR_J   = 3'd5,
        ST_FINISH = 3'd6
    } state_t;

    // Externally visible phase encodings.
    localparam logic [1:0] PHASE_IDLE   = 2'd0;
    localparam logic [1:0] PHASE_INIT   = 2'd1;
    localparam logic [1:0] PHASE_SHUF   = 2'd2;
    localparam logic [1:0] PHASE_FINISH = 2'd3;

    // Bit positions inside the mode input.
    localparam int MODE_INIT_B = 0;
    localparam int MODE_SHUF_B = 1;

    // Map a sequencer state onto the coarse phase reported to the control FSM.
    function automatic logic [1:0] phase_of(state_t s);
        case (s)
            ST_INIT:                             return PHASE_INIT;
            ST_RD_I, ST_RD_J, ST_WR_I, ST_WR_J:  return PHASE_SHUF;
            ST_FINISH:                           return PHASE_FINISH;
            default:                             return PHASE_IDLE;
        endcase
    endfunction

    // Width of the key-byte index; a one-byte key still needs a one-bit index.
    function automatic int kidx_width(int key_bytes);
        return (key_bytes > 1) ? $clog2(key_bytes) : 1;
    endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// rc4_key_byte_sel: picks key byte kidx from the latched key.
// Byte 0 is the most significant byte of the key vector.
`timescale 1ns/1ps
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int KIDX_W    = kidx_width(KEY_BYTES)
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [KIDX_W-1:0]      kidx,
    output logic [7:0]             key_byte
);

    // Plain mux over the key bytes; out-of-range indices read as zero.
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx == KIDX_W'(b)) begin
                key_byte = key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/rc4_key_schedule.sv
// rc4_key_schedule: sequences RC4 identity init and key shuffle over a
// single-port synchronous S memory, with start/busy/done, mode and abort.
`timescale 1ns/1ps
module rc4_key_schedule
    import rc4_pkg::*;
#(
    parameter int N_W       = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   abort,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             phase,
    output logic [N_W-1:0]         mem_addr,
    output logic [N_W-1:0]         mem_wdata,
    output logic                   mem_wren,
    input  logic [N_W-1:0]         mem_rdata
);

    localparam int             KIDX_W = kidx_width(KEY_BYTES);
    localparam logic [N_W-1:0] I_LAST = '1;

    state_t                 state;
    state_t                 state_next;
    logic [N_W-1:0]         i;
    logic [N_W-1:0]         j;
    logic [N_W-1:0]         si;
    logic [KIDX_W-1:0]      kidx;
    logic [8*KEY_BYTES-1:0] key_r;
    logic                   shuf_r;
    logic [7:0]             key_byte;
    logic [N_W-1:0]         key_byte_n;
    logic [N_W-1:0]         jn;

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES),
        .KIDX_W    (KIDX_W)
    ) u_key_byte_sel (
        .key      (key_r),
        .kidx     (kidx),
        .key_byte (key_byte)
    );

    // Key byte folded to the S width, and the candidate j while S[i] is on rdata.
    always_comb begin
        key_byte_n = N_W'(key_byte);
        jn         = j + mem_rdata + key_byte_n;
    end

    // Next-state selection; abort overrides every transition.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode == 2'b00)           state_next = ST_FINISH;
                        else if (mode[MODE_INIT_B])  state_next = ST_INIT;
                        else                         state_next = ST_RD_I;
                    end
                end
                ST_INIT: begin
                    if (i == I_LAST) state_next = shuf_r ? ST_RD_I : ST_FINISH;
                end
                ST_RD_I:   state_next = ST_RD_J;
                ST_RD_J:   state_next = ST_WR_I;
                ST_WR_I:   state_next = ST_WR_J;
                ST_WR_J:   state_next = (i == I_LAST) ? ST_FINISH : ST_RD_I;
                ST_FINISH: state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Memory port driven from the current state; RD_J forwards jn straight to the address.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        case (state)
            ST_INIT: begin
                mem_addr  = i;
                mem_wdata = i;
                mem_wren  = 1'b1;
            end
            ST_RD_I: mem_addr = i;
            ST_RD_J: mem_addr = jn;
            ST_WR_I: begin
                mem_addr  = i;
                mem_wdata = mem_rdata;
                mem_wren  = 1'b1;
            end
            ST_WR_J: begin
                mem_addr  = j;
                mem_wdata = si;
                mem_wren  = 1'b1;
            end
            default: ;
        endcase
    end

    // State register, registered status outputs and the i/j/kidx/si datapath.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            phase  <= PHASE_IDLE;
            i      <= '0;
            j      <= '0;
            si     <= '0;
            kidx   <= '0;
            key_r  <= '0;
            shuf_r <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE) && (state_next != ST_FINISH);
            done  <= (state_next == ST_FINISH);
            phase <= phase_of(state_next);
            if (!abort) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            key_r  <= key;
                            shuf_r <= mode[MODE_SHUF_B];
                            i      <= '0;
                            j      <= '0;
                            kidx   <= '0;
                        end
                    end
                    ST_INIT: i <= i + 1'b1;
                    ST_RD_J: begin
                        si <= mem_rdata;
                        j  <= jn;
                    end
                    ST_WR_J: begin
                        i    <= i + 1'b1;
                        kidx <= (kidx == KIDX_W'(KEY_BYTES-1)) ? '0 : kidx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_key_schedule.sv
// tb_rc4_key_schedule: drives a small (N_W=2) and a full-size (N_W=8) engine,
// each against a behavioural sync RAM, and compares every cycle with a trace
// derived from a software RC4 key schedule.
`timescale 1ns/1ps
module tb_rc4_key_schedule;

    typedef struct {
        bit busy;
        bit done;
        int phase;
        bit wren;
        bit chk_addr;
        int addr;
        bit chk_wdata;
        int wdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;

    logic        start2, abort2, busy2, done2, wren2, preload2;
    logic [1:0]  mode2, phase2, addr2, wdata2, rdata2;
    logic [15:0] key2;
    logic [1:0]  ram2 [4];

    logic        start8, abort8, busy8, done8, wren8;
    logic [1:0]  mode8, phase8;
    logic [7:0]  addr8, wdata8, rdata8;
    logic [23:0] key8;
    logic [7:0]  ram8 [256];

    int   mdl2 [4];
    int   mdl8 [256];
    exp_t q2 [$];
    exp_t q8 [$];
    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b0;

    rc4_key_schedule #(.N_W(2), .KEY_BYTES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .mode(mode2), .abort(abort2),
        .key(key2), .busy(busy2), .done(done2), .phase(phase2), .mem_addr(addr2),
        .mem_wdata(wdata2), .mem_wren(wren2), .mem_rdata(rdata2)
    );

    rc4_key_schedule #(.N_W(8), .KEY_BYTES(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .mode(mode8), .abort(abort8),
        .key(key8), .busy(busy8), .done(done8), .phase(phase8), .mem_addr(addr8),
        .mem_wdata(wdata8), .mem_wren(wren8), .mem_rdata(rdata8)
    );

    always #5 clk = ~clk;

    // Small S memory, with a one-shot identity preload used by the shuffle-only test.
    always @(posedge clk) begin
        if (preload2) begin
            for (int x = 0; x < 4; x++) ram2[x] <= 2'(x);
        end else if (wren2) begin
            ram2[addr2] <= wdata2;
        end
        rdata2 <= ram2[addr2];
    end

    // Full-size S memory.
    always @(posedge clk) begin
        if (wren8) ram8[addr8] <= wdata8;
        rdata8 <= ram8[addr8];
    end

    function automatic exp_t make_exp(bit b, bit d, int p, bit w, bit ca, int a, bit cw, int wd);
        exp_t e;
        e.busy = b; e.done = d; e.phase = p; e.wren = w;
        e.chk_addr = ca; e.addr = a; e.chk_wdata = cw; e.wdata = wd;
        return e;
    endfunction

    task automatic expect_eq(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_exp(bit sel, exp_t e);
        if (sel) q8.push_back(e);
        else     q2.push_back(e);
    endtask

    // Expected per-cycle trace of a run starting now (entry 0 is the start cycle),
    // obtained by running the RC4 key schedule in software on the model memory.
    task automatic buildTrace(bit sel, logic [1:0] m, logic [23:0] k);
        int n    = sel ? 256 : 4;
        int klen = sel ? 3 : 2;
        int kv   = int'(k);
        int s [256];
        int j    = 0;
        int kb, jn, t;
        for (int x = 0; x < n; x++) s[x] = sel ? mdl8[x] : mdl2[x];
        push_exp(sel, make_exp(0, 0, 0, 0, 0, 0, 0, 0));
        if (m[0]) begin
            for (int x = 0; x < n; x++) begin
                push_exp(sel, make_exp(1, 0, 1, 1, 1, x, 1, x));
                s[x] = x;
            end
        end
        if (m[1]) begin
            for (int x = 0; x < n; x++) begin
                kb = (kv >> (8 * (klen - 1 - (x % klen)))) & 255;
                kb = kb % n;
                jn = (j + s[x] + kb) % n;
                push_exp(sel, make_exp(1, 0, 2, 0, 1, x,  0, 0));
                push_exp(sel, make_exp(1, 0, 2, 0, 1, jn, 0, 0));
                push_exp(sel, make_exp(1, 0, 2, 1, 1, x,  1, s[jn]));
                push_exp(sel, make_exp(1, 0, 2, 1, 1, jn, 1, s[x]));
                t = s[x]; s[x] = s[jn]; s[jn] = t;
                j = jn;
            end
        end
        push_exp(sel, make_exp(0, 1, 3, 0, 0, 0, 0, 0));
        for (int x = 0; x < n; x++) begin
            if (sel) mdl8[x] = s[x];
            else     mdl2[x] = s[x];
        end
    endtask

    // Start a run: pulse start for one cycle and queue the expected trace.
    task automatic applyStimulus(bit sel, logic [1:0] m, logic [23:0] k);
        @(posedge clk); #2;
        buildTrace(sel, m, k);
        if (sel) begin mode8 = m; key8 = k;        start8 = 1'b1; end
        else     begin mode2 = m; key2 = k[15:0];  start2 = 1'b1; end
        @(posedge clk); #2;
        start2 = 1'b0;
        start8 = 1'b0;
    endtask

    // Compare one engine's outputs against the head of its expected trace.
    task automatic checkOutput(bit sel);
        exp_t  e;
        string p = sel ? "s8" : "s2";
        if (sel) e = (q8.size() > 0) ? q8.pop_front() : make_exp(0, 0, 0, 0, 0, 0, 0, 0);
        else     e = (q2.size() > 0) ? q2.pop_front() : make_exp(0, 0, 0, 0, 0, 0, 0, 0);
        expect_eq({p, ".busy"},  sel ? 32'(busy8)  : 32'(busy2),  32'(e.busy));
        expect_eq({p, ".done"},  sel ? 32'(done8)  : 32'(done2),  32'(e.done));
        expect_eq({p, ".phase"}, sel ? 32'(phase8) : 32'(phase2), 32'(e.phase));
        expect_eq({p, ".wren"},  sel ? 32'(wren8)  : 32'(wren2),  32'(e.wren));
        if (e.chk_addr)
            expect_eq({p, ".addr"}, sel ? 32'(addr8) : 32'(addr2), 32'(e.addr));
        if (e.chk_wdata)
            expect_eq({p, ".wdata"}, sel ? 32'(wdata8) : 32'(wdata2), 32'(e.wdata));
    endtask

    // Per-cycle compare of both engines, sampled on the falling edge.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput(1'b0);
            checkOutput(1'b1);
        end
    end

    task automatic checkReset();
        expect_eq("rst.s2.busy",  32'(busy2),  0);
        expect_eq("rst.s2.done",  32'(done2),  0);
        expect_eq("rst.s2.phase", 32'(phase2), 0);
        expect_eq("rst.s2.wren",  32'(wren2),  0);
        expect_eq("rst.s2.addr",  32'(addr2),  0);
        expect_eq("rst.s2.wdata", 32'(wdata2), 0);
        expect_eq("rst.s8.busy",  32'(busy8),  0);
        expect_eq("rst.s8.done",  32'(done8),  0);
        expect_eq("rst.s8.phase", 32'(phase8), 0);
        expect_eq("rst.s8.wren",  32'(wren8),  0);
        expect_eq("rst.s8.addr",  32'(addr8),  0);
        expect_eq("rst.s8.wdata", 32'(wdata8), 0);
    endtask

    // Called in cycle 1 of a run: count cycles until done, bounded.
    task automatic waitDone(bit sel, int req_cycle, string name);
        int n = 1;
        while (n <= req_cycle + 40) begin
            if ((sel ? done8 : done2) === 1'b1) break;
            @(posedge clk); #2;
            n++;
        end
        expect_eq(name, n, req_cycle);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic compareRam(bit sel, string name);
        int n = sel ? 256 : 4;
        for (int x = 0; x < n; x++) begin
            if (sel) expect_eq($sformatf("%s[%0d]", name, x), 32'(ram8[x]), mdl8[x]);
            else     expect_eq($sformatf("%s[%0d]", name, x), 32'(ram2[x]), mdl2[x]);
        end
    endtask

    task automatic compareLit2(string name, int lit [4]);
        for (int x = 0; x < 4; x++)
            expect_eq($sformatf("%s[%0d]", name, x), 32'(ram2[x]), lit[x]);
    endtask

    initial begin
        int lit_a [4];
        int lit_b [4];
        int lit_id [4];
        logic [1:0]  m;
        logic [23:0] k;
        lit_a  = '{0, 2, 3, 1};
        lit_b  = '{2, 1, 3, 0};
        lit_id = '{0, 1, 2, 3};

        reset_n = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; mode2 = 2'b00; key2 = '0; preload2 = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; mode8 = 2'b00; key8 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkReset();
        reset_n  = 1'b1;
        checking = 1'b1;

        $display("[TB] small engine, fixed vectors");
        applyStimulus(1'b0, 2'b11, 24'h000000);
        waitDone(1'b0, 21, "s2.k00.done_cycle");
        compareLit2("s2.k00.S", lit_a);
        compareRam(1'b0, "s2.k00.model");

        applyStimulus(1'b0, 2'b11, 24'h000103);
        waitDone(1'b0, 21, "s2.k0103.done_cycle");
        compareLit2("s2.k0103.S", lit_b);

        @(posedge clk); #2; preload2 = 1'b1;
        @(posedge clk); #2; preload2 = 1'b0;
        for (int x = 0; x < 4; x++) mdl2[x] = x;
        applyStimulus(1'b0, 2'b10, 24'h000000);
        waitDone(1'b0, 17, "s2.m10.done_cycle");
        compareLit2("s2.m10.S", lit_a);

        applyStimulus(1'b0, 2'b01, 24'h000000);
        waitDone(1'b0, 5, "s2.m01.done_cycle");
        compareLit2("s2.m01.S", lit_id);

        applyStimulus(1'b0, 2'b00, 24'h000000);
        waitDone(1'b0, 1, "s2.m00.done_cycle");
        compareLit2("s2.m00.S", lit_id);

        $display("[TB] small engine, random modes and keys");
        for (int r = 0; r < 8; r++) begin
            m = 2'($urandom_range(0, 3));
            k = 24'($urandom & 32'h0000FFFF);
            applyStimulus(1'b0, m, k);
            waitDone(1'b0, (m[0] ? 4 : 0) + (m[1] ? 16 : 0) + 1, "s2.rand.done_cycle");
            compareRam(1'b0, "s2.rand.S");
        end

        $display("[TB] full-size engine, key 00 02 49");
        applyStimulus(1'b1, 2'b11, 24'h000249);
        waitDone(1'b1, 1281, "s8.k000249.done_cycle");
        compareRam(1'b1, "s8.k000249.S");

        $display("[TB] full-size engine, ignored start then abort in RD_J of i=100");
        applyStimulus(1'b1, 2'b11, 24'($urandom));
        repeat (299) @(posedge clk);
        #2; start8 = 1'b1; mode8 = 2'b00;
        @(posedge clk); #2; start8 = 1'b0;
        repeat (357) @(posedge clk);
        #2; abort8 = 1'b1;
        @(posedge clk); #1;
        q8.delete();
        abort8 = 1'b0;
        repeat (20) @(posedge clk);
        #2;

        $display("[TB] full-size engine, reset mid-init then a fresh run");
        applyStimulus(1'b1, 2'b11, 24'($urandom));
        repeat (99) @(posedge clk);
        #2; reset_n = 1'b0;
        @(posedge clk); #1;
        q8.delete();
        checkReset();
        reset_n = 1'b1;
        k = 24'($urandom);
        applyStimulus(1'b1, 2'b11, k);
        waitDone(1'b1, 1281, "s8.after_reset.done_cycle");
        compareRam(1'b1, "s8.after_reset.S");

        repeat (4) @(posedge clk);
        #2;
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
